// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus of the sequential divider.
// The master drives the request; the slave (the divider) returns the results.
interface seq_divider_if #(
    parameter int unsigned WIDTH = 4
);
    logic                   start;
    logic [2*WIDTH-1:0]     dividend;
    logic [WIDTH-1:0]       divisor;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]       remainder;
    logic                   div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Sequential restoring unsigned divider: 2W-bit dividend / W-bit divisor,
// one quotient bit per clock, with a one-cycle done pulse and held results.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_divider_if.slave  bus
);
    localparam int unsigned QW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (QW > 2) ? $clog2(QW) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [QW-1:0]      r_dvd;
    logic [WIDTH-1:0]   r_dvs;
    logic [WIDTH-1:0]   r_part;
    logic [QW-1:0]      r_q;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [QW-1:0]      r_quot;
    logic [WIDTH-1:0]   r_rem;
    logic               r_dz;

    logic [QW-1:0]      w_dvd_nxt;
    logic [WIDTH-1:0]   w_dvs_nxt;
    logic [WIDTH-1:0]   w_part_nxt;
    logic [QW-1:0]      w_q_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic [QW-1:0]      w_quot_nxt;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic               w_dz_nxt;

    logic [WIDTH:0]     w_trial;
    logic [WIDTH:0]     w_diff;
    logic               w_ge;
    logic [WIDTH-1:0]   w_step_part;
    logic [QW-1:0]      w_step_q;
    logic               w_last;

    // One restoring step; the borrow out of the (WIDTH+1)-bit difference is the compare.
    assign w_trial     = {r_part, r_dvd[QW-1]};
    assign w_diff      = w_trial - {1'b0, r_dvs};
    assign w_ge        = ~w_diff[WIDTH];
    assign w_step_part = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
    assign w_step_q    = {r_q[QW-2:0], w_ge};
    assign w_last      = (r_cnt == CNT_W'(QW - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_part  <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_dvd   <= w_dvd_nxt;
            r_dvs   <= w_dvs_nxt;
            r_part  <= w_part_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_quot  <= w_quot_nxt;
            r_rem   <= w_rem_nxt;
            r_dz    <= w_dz_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = (bus.divisor == '0) ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and result registers only change on acceptance, per step, and on DONE entry.
    always_comb begin
        w_dvd_nxt  = r_dvd;
        w_dvs_nxt  = r_dvs;
        w_part_nxt = r_part;
        w_q_nxt    = r_q;
        w_cnt_nxt  = r_cnt;
        w_quot_nxt = r_quot;
        w_rem_nxt  = r_rem;
        w_dz_nxt   = r_dz;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = (w_state_nxt == S_DONE);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        w_quot_nxt = '1;
                        w_rem_nxt  = bus.dividend[WIDTH-1:0];
                        w_dz_nxt   = 1'b1;
                    end else begin
                        w_dvd_nxt  = bus.dividend;
                        w_dvs_nxt  = bus.divisor;
                        w_part_nxt = '0;
                        w_q_nxt    = '0;
                        w_cnt_nxt  = '0;
                        w_dz_nxt   = 1'b0;
                    end
                end
            end
            S_CALC: begin
                w_dvd_nxt  = {r_dvd[QW-2:0], 1'b0};
                w_part_nxt = w_step_part;
                w_q_nxt    = w_step_q;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (w_last) begin
                    w_quot_nxt = w_step_q;
                    w_rem_nxt  = w_step_part;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rem;
    assign bus.div_zero  = r_dz;
endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider (WIDTH=4): directed cases, start/reset
// corner cases, randomized operations and an exhaustive back-to-back sweep.
module tb_seq_divider;
    localparam int unsigned W  = 4;
    localparam int unsigned QW = 2 * W;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    seq_divider_if #(.WIDTH(W)) bus ();

    seq_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer division, with the documented divide-by-zero convention.
    function automatic void model(input int dd, input int ds,
                                  output int q, output int r, output bit dz);
        if (ds == 0) begin
            q  = (1 << QW) - 1;
            r  = dd % (1 << W);
            dz = 1'b1;
        end else begin
            q  = dd / ds;
            r  = dd % ds;
            dz = 1'b0;
        end
    endfunction

    // Issue one start pulse and wait for done; inputs are scrambled after acceptance.
    task automatic run_op(input int dd, input int ds, input bit scramble,
                          output int q, output int r, output bit dz,
                          output int lat, output bit busy_ok, output bit got);
        bus.start    = 1'b1;
        bus.dividend = QW'(dd);
        bus.divisor  = W'(ds);
        @(negedge clk);
        bus.start = 1'b0;
        if (scramble) begin
            bus.dividend = QW'($urandom);
            bus.divisor  = W'($urandom);
        end
        lat     = 0;
        busy_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.busy !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        got = (bus.done === 1'b1);
        if (bus.busy !== 1'b1) busy_ok = 1'b0;
        q  = int'(bus.quotient);
        r  = int'(bus.remainder);
        dz = bus.div_zero;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.div_zero});
        end
        checks++;
        if (bus.quotient !== '0 || bus.remainder !== '0) begin
            failures++;
            $display("FAIL reset_results got q=%0d r=%0d want q=0 r=0", bus.quotient, bus.remainder);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_directed();
        int dd_t [6] = '{200, 255, 0, 225, 5, 100};
        int ds_t [6] = '{7, 1, 15, 15, 0, 3};
        int q, r, lat, eq, er, elat;
        bit dz, edz, bok, got;
        for (int i = 0; i < 6; i++) begin
            model(dd_t[i], ds_t[i], eq, er, edz);
            elat = edz ? 0 : int'(QW);
            run_op(dd_t[i], ds_t[i], 1'b0, q, r, dz, lat, bok, got);
            checks++;
            if (!got || q != eq || r != er || dz != edz) begin
                failures++;
                $display("FAIL directed_%0d/%0d got done=%0b q=%0d r=%0d dz=%0b want q=%0d r=%0d dz=%0b",
                         dd_t[i], ds_t[i], got, q, r, dz, eq, er, edz);
            end
            checks++;
            if (lat != elat) begin
                failures++;
                $display("FAIL latency_%0d/%0d got=%0d want=%0d", dd_t[i], ds_t[i], lat, elat);
            end
            checks++;
            if (!bok) begin
                failures++;
                $display("FAIL busy_window_%0d/%0d got busy low while busy required", dd_t[i], ds_t[i]);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.quotient) != eq) begin
                failures++;
                $display("FAIL after_done_%0d/%0d got done=%b busy=%b q=%0d want 0 0 q=%0d",
                         dd_t[i], ds_t[i], bus.done, bus.busy, bus.quotient, eq);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones = 0;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (bus.done === 1'b1) begin
                dones++;
                checks++;
                if (bus.quotient !== 8'd33 || bus.remainder !== 4'd1) begin
                    failures++;
                    $display("FAIL ignore_start got q=%0d r=%0d want q=33 r=1", bus.quotient, bus.remainder);
                end
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            failures++;
            $display("FAIL ignore_start_dones got=%0d want=1", dones);
        end
    endtask

    task automatic test_reset_mid();
        int q, r, lat, dones = 0;
        bit dz, bok, got;
        bus.start = 1'b1; bus.dividend = 8'd100; bus.divisor = 4'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_zero} !== 3'b000 || bus.quotient !== '0 || bus.remainder !== '0) begin
            failures++;
            $display("FAIL reset_mid got busy=%b done=%b dz=%b q=%0d r=%0d want all 0",
                     bus.busy, bus.done, bus.div_zero, bus.quotient, bus.remainder);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got=%0d want=0", dones);
        end
        run_op(100, 3, 1'b0, q, r, dz, lat, bok, got);
        checks++;
        if (!got || q != 33 || r != 1 || dz) begin
            failures++;
            $display("FAIL after_reset_op got done=%0b q=%0d r=%0d dz=%0b want q=33 r=1 dz=0", got, q, r, dz);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int dd, ds, q, r, lat, eq, er;
        bit dz, edz, bok, got;
        for (int i = 0; i < 200; i++) begin
            dd = int'($urandom_range(255, 0));
            ds = (i % 10 == 0) ? 0 : int'($urandom_range(15, 0));
            model(dd, ds, eq, er, edz);
            run_op(dd, ds, 1'b1, q, r, dz, lat, bok, got);
            checks++;
            if (!got || q != eq || r != er || dz != edz || lat != (edz ? 0 : int'(QW))) begin
                failures++;
                $display("FAIL random_%0d/%0d got done=%0b q=%0d r=%0d dz=%0b lat=%0d want q=%0d r=%0d dz=%0b",
                         dd, ds, got, q, r, dz, lat, eq, er, edz);
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    // Start stays high: each new operation is accepted as soon as IDLE is re-entered.
    task automatic test_back_to_back();
        int q, r, k, starts = 0, dones = 0, bad = 0;
        bus.start = 1'b1;
        for (int ds = 1; ds < 16; ds++) begin
            for (int dd = 0; dd < 256; dd++) begin
                bus.dividend = QW'(dd);
                bus.divisor  = W'(ds);
                starts++;
                k = 0;
                do begin
                    @(negedge clk);
                    k++;
                end while (bus.done !== 1'b1 && k < 20);
                if (bus.done === 1'b1) dones++;
                q = int'(bus.quotient);
                r = int'(bus.remainder);
                checks++;
                if (q * ds + r != dd || r >= ds || q != dd / ds || bus.div_zero !== 1'b0) begin
                    failures++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL b2b_%0d/%0d got q=%0d r=%0d dz=%b want q=%0d r=%0d dz=0",
                                 dd, ds, q, r, bus.div_zero, dd / ds, dd % ds);
                end
            end
        end
        bus.start = 1'b0;
        checks++;
        if (dones != starts) begin
            failures++;
            $display("FAIL b2b_done_count got=%0d want=%0d", dones, starts);
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
